// File: rtl/ir_nec_rx.sv
// NEC IR frame decoder: synchronises the raw receiver line, measures pulse widths between edges
// and assembles 32-bit frames, flagging repeat codes and aborted frames with one-cycle strobes.
module ir_nec_rx #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter bit          CHECK_INV = 1'b1,
  parameter int unsigned CNT_W     = 22
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ir_in,
  output logic [31:0] ir_data,
  output logic        ir_data_vld,
  output logic        ir_repeat,
  output logic        ir_err,
  output logic        busy
);

  function automatic logic [CNT_W-1:0] us2cyc(input longint unsigned us);
    return CNT_W'(us * longint'(CLK_FREQ) / 64'd1_000_000);
  endfunction

  localparam logic [CNT_W-1:0] LeadLMin = us2cyc(8000);
  localparam logic [CNT_W-1:0] LeadLMax = us2cyc(10000);
  localparam logic [CNT_W-1:0] LeadHMin = us2cyc(4000);
  localparam logic [CNT_W-1:0] LeadHMax = us2cyc(5000);
  localparam logic [CNT_W-1:0] RptHMin  = us2cyc(2000);
  localparam logic [CNT_W-1:0] RptHMax  = us2cyc(2500);
  localparam logic [CNT_W-1:0] BurstMin = us2cyc(400);
  localparam logic [CNT_W-1:0] BurstMax = us2cyc(700);
  localparam logic [CNT_W-1:0] OneMin   = us2cyc(1400);
  localparam logic [CNT_W-1:0] OneMax   = us2cyc(1900);

  function automatic logic in_win(input logic [CNT_W-1:0] v, input logic [CNT_W-1:0] lo,
                                  input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  typedef enum logic [2:0] {StIdle, StLeadL, StLeadH, StBitL, StBitH, StStop, StRptL} state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       bit_idx_q, bit_idx_d;
  logic [31:0]      shift_q, shift_d;
  logic [31:0]      data_q, data_d;
  logic             vld_q, vld_d, rpt_q, rpt_d, err_q, err_d;
  logic             fall, rise, inv_ok;

  assign fall   = s3_q & ~s2_q;
  assign rise   = ~s3_q & s2_q;
  assign inv_ok = (shift_q[31:24] == ~shift_q[23:16]) && (shift_q[15:8] == ~shift_q[7:0]);

  always_comb begin
    cnt_d     = (fall || rise) ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    vld_d     = 1'b0;
    rpt_d     = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: if (fall) state_d = StLeadL;
      StLeadL: begin
        if (cnt_q > LeadLMax) state_d = StIdle;
        else if (rise) state_d = in_win(cnt_q, LeadLMin, LeadLMax) ? StLeadH : StIdle;
      end
      StLeadH: begin
        if (cnt_q > LeadHMax) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (fall) begin
          if (in_win(cnt_q, LeadHMin, LeadHMax)) begin
            bit_idx_d = '0;
            state_d   = StBitL;
          end else if (in_win(cnt_q, RptHMin, RptHMax)) begin
            state_d = StRptL;
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end
      end
      StBitL: begin
        if (cnt_q > BurstMax || (rise && !in_win(cnt_q, BurstMin, BurstMax))) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (rise) begin
          state_d = StBitH;
        end
      end
      StBitH: begin
        if (cnt_q > OneMax || (fall && !in_win(cnt_q, BurstMin, BurstMax)
                                    && !in_win(cnt_q, OneMin, OneMax))) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (fall) begin
          // Byte k lands in [31-8k -: 8], LSB first, i.e. position {~k, i}.
          shift_d[{~bit_idx_q[4:3], bit_idx_q[2:0]}] = in_win(cnt_q, OneMin, OneMax);
          bit_idx_d = bit_idx_q + 5'd1;
          state_d   = (bit_idx_q == 5'd31) ? StStop : StBitL;
        end
      end
      StStop: begin
        if (cnt_q > BurstMax || (rise && !in_win(cnt_q, BurstMin, BurstMax))) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (rise) begin
          state_d = StIdle;
          if (!CHECK_INV || inv_ok) begin
            data_d = shift_q;
            vld_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRptL: begin
        if (cnt_q > BurstMax || (rise && !in_win(cnt_q, BurstMin, BurstMax))) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (rise) begin
          state_d = StIdle;
          rpt_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      s3_q      <= 1'b1;
      cnt_q     <= '0;
      state_q   <= StIdle;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      vld_q     <= 1'b0;
      rpt_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      s1_q      <= ir_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      rpt_q     <= rpt_d;
      err_q     <= err_d;
    end
  end

  assign ir_data     = data_q;
  assign ir_data_vld = vld_q;
  assign ir_repeat   = rpt_q;
  assign ir_err      = err_q;
  assign busy        = (state_q != StIdle);

endmodule
